// File: rtl/uart_param_if.sv
// Valid/ready byte streams between a UART and its user: TX toward the line, RX back from it.
interface uart_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with oversampled, majority-voted receiver.
// Define UART_RX_FIFO_EN to buffer received frames in an RX_FIFO_DEPTH-entry FIFO.
module uart_param #(
  parameter int CLK_HZ        = 100000000,
  parameter int BAUD          = 115200,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int LOOPBACK      = 0,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_param_if.slave bus,
  output logic        tx_out,
  input  logic        rx_in
);
  localparam int DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE);
  localparam int T   = DIV * OVERSAMPLE;
  localparam int TW  = $clog2(T + 1);
  localparam int DW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state_reg;
  logic [TW-1:0]        tx_cnt_reg;
  logic [3:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 tx_out_reg;
  logic                 tx_ready_reg;
  logic                 tx_bit_end;

  assign tx_bit_end   = (tx_cnt_reg == TW'(T - 1));
  assign tx_out       = tx_out_reg;
  assign bus.tx_ready = tx_ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_out_reg   <= 1'b1;
      tx_ready_reg <= 1'b1;
    end else begin
      tx_cnt_reg <= tx_bit_end ? '0 : tx_cnt_reg + 1'b1;
      case (tx_state_reg)
        TX_IDLE: begin
          if (bus.tx_valid) begin
            tx_shift_reg <= bus.tx_data;
            tx_par_reg   <= (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_out_reg   <= 1'b0;
            tx_ready_reg <= 1'b0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_out_reg   <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_state_reg <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_reg == 4'(DATA_BITS - 1)) begin
              tx_bit_reg <= '0;
              if (PARITY != 0) begin
                tx_out_reg   <= tx_par_reg;
                tx_state_reg <= TX_PARITY;
              end else begin
                tx_out_reg   <= 1'b1;
                tx_state_reg <= TX_STOP;
              end
            end else begin
              tx_out_reg   <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_bit_reg   <= tx_bit_reg + 1'b1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_out_reg   <= 1'b1;
            tx_state_reg <= TX_STOP;
          end
        end
        TX_STOP: begin
          // Ready one cycle early so a waiting byte starts exactly T after the last stop bit began.
          if (tx_bit_reg == 4'(STOP_BITS - 1) && tx_cnt_reg == TW'(T - 2)) begin
            tx_ready_reg <= 1'b1;
            tx_state_reg <= TX_IDLE;
          end else if (tx_bit_end) begin
            tx_bit_reg <= tx_bit_reg + 1'b1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK_WAIT} rx_state_t;

  rx_state_t            rx_state_reg;
  logic                 rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
  logic [DW-1:0]        div_cnt_reg;
  logic [SW-1:0]        smp_cnt_reg;
  logic [1:0]           smp_reg;
  logic [3:0]           rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_perr_reg;
  logic                 done_reg;
  logic                 done_ferr_reg;
  logic                 overrun_reg;
  logic                 rx_line, tick, smp_last, mid_tick, end_tick, vote, exp_par;

  assign rx_line  = (LOOPBACK != 0) ? tx_out_reg : rx_in;
  assign tick     = (div_cnt_reg == DW'(DIV - 1));
  assign smp_last = (smp_cnt_reg == SW'(OVERSAMPLE - 1));
  assign mid_tick = tick && (smp_cnt_reg == SW'(OVERSAMPLE/2 + 1));
  assign end_tick = tick && smp_last;
  // Third vote is the live sample taken on the decision tick itself.
  assign vote     = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & rx_sync2_reg) | (smp_reg[1] & rx_sync2_reg);
  assign exp_par  = (PARITY == 1) ? ~^rx_shift_reg : ^rx_shift_reg;
  assign bus.rx_overrun = overrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_reg  <= 1'b1;
      rx_sync2_reg  <= 1'b1;
      rx_prev_reg   <= 1'b1;
      div_cnt_reg   <= '0;
      smp_cnt_reg   <= '0;
      smp_reg       <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      rx_perr_reg   <= 1'b0;
      done_reg      <= 1'b0;
      done_ferr_reg <= 1'b0;
      rx_state_reg  <= RX_IDLE;
    end else begin
      rx_sync1_reg <= rx_line;
      rx_sync2_reg <= rx_sync1_reg;
      rx_prev_reg  <= rx_sync2_reg;
      div_cnt_reg  <= tick ? '0 : div_cnt_reg + 1'b1;
      done_reg     <= 1'b0;
      if (tick) begin
        smp_cnt_reg <= smp_last ? '0 : smp_cnt_reg + 1'b1;
        if (smp_cnt_reg == SW'(OVERSAMPLE/2 - 1)) smp_reg[0] <= rx_sync2_reg;
        if (smp_cnt_reg == SW'(OVERSAMPLE/2))     smp_reg[1] <= rx_sync2_reg;
      end
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync2_reg) begin
            smp_cnt_reg  <= '0;
            rx_perr_reg  <= 1'b0;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (mid_tick && vote) begin
            rx_state_reg <= RX_IDLE;
          end else if (end_tick) begin
            rx_bit_reg   <= '0;
            rx_state_reg <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (mid_tick) rx_shift_reg <= {vote, rx_shift_reg[DATA_BITS-1:1]};
          if (end_tick) begin
            if (rx_bit_reg == 4'(DATA_BITS - 1)) begin
              rx_state_reg <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (mid_tick) rx_perr_reg <= vote ^ exp_par;
          if (end_tick) rx_state_reg <= RX_STOP;
        end
        RX_STOP: begin
          if (mid_tick) begin
            done_reg      <= 1'b1;
            done_ferr_reg <= ~vote;
            rx_state_reg  <= vote ? RX_IDLE : RX_BREAK_WAIT;
          end
        end
        RX_BREAK_WAIT: begin
          if (tick && rx_sync2_reg) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [DATA_BITS+1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic [DATA_BITS+1:0] head;
  logic                 fifo_full, fifo_pop, fifo_push;

  assign fifo_full = (count_reg == RX_FIFO_DEPTH[AW:0]);
  assign fifo_pop  = (count_reg != '0) && bus.rx_ready;
  assign fifo_push = done_reg && (!fifo_full || fifo_pop);
  // Head read is combinational so the output falls through without an extra cycle.
  assign head      = (count_reg != '0) ? fifo_mem[rd_ptr_reg] : '0;

  assign bus.rx_valid      = (count_reg != '0);
  assign bus.rx_data       = head[DATA_BITS-1:0];
  assign bus.rx_frame_err  = head[DATA_BITS];
  assign bus.rx_parity_err = head[DATA_BITS+1];

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= {rx_perr_reg, done_ferr_reg, rx_shift_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      overrun_reg <= done_reg && fifo_full && !fifo_pop;
    end
  end
`else
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg, rx_ferr_out_reg, rx_perr_out_reg;

  assign bus.rx_valid      = rx_valid_reg;
  assign bus.rx_data       = rx_data_reg;
  assign bus.rx_frame_err  = rx_ferr_out_reg;
  assign bus.rx_parity_err = rx_perr_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      rx_ferr_out_reg <= 1'b0;
      rx_perr_out_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (done_reg) begin
        if (!rx_valid_reg || bus.rx_ready) begin
          rx_data_reg     <= rx_shift_reg;
          rx_ferr_out_reg <= done_ferr_reg;
          rx_perr_out_reg <= rx_perr_reg;
          rx_valid_reg    <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && bus.rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_uart_param.sv
// Directed bench: default-rate TX and async reset, fast-rate loopback with parity, RX error paths.
module tb_uart_param;
  localparam int TA      = 864;      // bit period at default parameters
  localparam int FAST_HZ = 9216000;  // DIV = 5 at 115200 x16
  localparam int TC      = 80;       // bit period of the fast instances

  logic clk = 1'b0;
  logic rst_n, rst_a_n;
  logic tx_a, tx_b, tx_c;
  logic rx_a, rx_b, rx_c;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ovr_cnt = 0;
  logic [9:0] bq[$];
  logic [9:0] cq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_param_if #(.DATA_BITS(8)) a_if ();
  uart_param_if #(.DATA_BITS(8)) b_if ();
  uart_param_if #(.DATA_BITS(8)) c_if ();

  uart_param u_a (.clk(clk), .rst_n(rst_a_n), .bus(a_if), .tx_out(tx_a), .rx_in(rx_a));
  uart_param #(.CLK_HZ(FAST_HZ), .PARITY(2), .LOOPBACK(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(b_if), .tx_out(tx_b), .rx_in(rx_b));
  uart_param #(.CLK_HZ(FAST_HZ))
    u_c (.clk(clk), .rst_n(rst_n), .bus(c_if), .tx_out(tx_c), .rx_in(rx_c));

  // Accepted RX transfers, packed as {parity_err, frame_err, data}.
  always @(negedge clk) begin
    if (b_if.rx_valid && b_if.rx_ready) bq.push_back({b_if.rx_parity_err, b_if.rx_frame_err, b_if.rx_data});
    if (c_if.rx_valid && c_if.rx_ready) cq.push_back({c_if.rx_parity_err, c_if.rx_frame_err, c_if.rx_data});
    if (c_if.rx_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rx_c = f[k];
      repeat (TC - 1) @(negedge clk);
    end
  endtask

  task automatic set_rx_ready_c(input logic v);
    @(posedge clk);
    #1 c_if.rx_ready = v;
  endtask

  initial begin
    logic [9:0] a_frame;
    logic [7:0] lb_vals [4];
    int         xfer_cyc [4];
    int         base, w, ovr_base;

    rst_n = 1'b0; rst_a_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    a_if.tx_data = '0; a_if.tx_valid = 1'b0; a_if.rx_ready = 1'b1;
    b_if.tx_data = '0; b_if.tx_valid = 1'b0; b_if.rx_ready = 1'b1;
    c_if.tx_data = '0; c_if.tx_valid = 1'b0; c_if.rx_ready = 1'b1;
    repeat (5) @(negedge clk);

    check_val("rst_tx_out",   tx_a, 1);
    check_val("rst_tx_ready", a_if.tx_ready, 1);
    check_val("rst_rx_valid", c_if.rx_valid, 0);
    check_val("rst_rx_data",  c_if.rx_data, 0);
    check_val("rst_errs",     {c_if.rx_frame_err, c_if.rx_parity_err, c_if.rx_overrun}, 0);
    rst_n = 1'b1; rst_a_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0xA5 frame at default rate, sampled mid-bit.
    a_frame = {1'b1, 8'hA5, 1'b0};
    a_if.tx_data = 8'hA5; a_if.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_if.tx_valid = 1'b0; a_if.tx_data = 8'h00;
    check_val("tx_ready_drop", a_if.tx_ready, 0);
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? TA/2 : TA) @(posedge clk);
      @(negedge clk);
      check_val($sformatf("tx_bit%0d", k), tx_a, a_frame[k]);
    end
    check_val("tx_ready_in_stop", a_if.tx_ready, 0);
    repeat (TA/2) @(posedge clk);
    @(negedge clk);
    check_val("tx_ready_at_10T", a_if.tx_ready, 1);
    check_val("tx_idle_line", tx_a, 1);

    // Asynchronous reset in the middle of a frame.
    a_if.tx_data = 8'h00; a_if.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_if.tx_valid = 1'b0;
    repeat (1500) @(negedge clk);
    check_val("rst_pre_tx_out", tx_a, 0);
    #2 rst_a_n = 1'b0;
    #1;
    check_val("rst_mid_tx_out", tx_a, 1);
    check_val("rst_mid_tx_ready", a_if.tx_ready, 1);
    @(negedge clk);
    rst_a_n = 1'b1;

    // Loopback with even parity, back-to-back frames.
    lb_vals[0] = 8'h00; lb_vals[1] = 8'hFF; lb_vals[2] = 8'h3C; lb_vals[3] = 8'h07;
    base = bq.size();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b_if.tx_data = lb_vals[i]; b_if.tx_valid = 1'b1;
      w = 0;
      while (!b_if.tx_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) check_val("lb_tx_ready_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      xfer_cyc[i] = cyc;
    end
    b_if.tx_valid = 1'b0;
    for (int i = 1; i < 4; i++) check_val($sformatf("lb_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], 11*TC);
    w = 0;
    while (bq.size() - base < 4 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check_val("lb_count", bq.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < bq.size()) check_val($sformatf("lb_rx%0d", i), bq[base+i], {2'b00, lb_vals[i]});

    // Stop bit 0 followed by a held-low line.
    base = cq.size();
    drive_frame(8'h55, 1'b0);
    @(negedge clk);
    rx_c = 1'b0;
    repeat (3*TC) @(negedge clk);
    rx_c = 1'b1;
    repeat (2*TC) @(negedge clk);
    check_val("ferr_count", cq.size() - base, 1);
    if (cq.size() > base) check_val("ferr_frame", cq[base], {2'b01, 8'h55});

    // Start-bit glitch of 5 sample ticks, then a clean frame.
    base = cq.size();
    rx_c = 1'b0;
    repeat (25) @(negedge clk);
    rx_c = 1'b1;
    repeat (2*TC) @(negedge clk);
    check_val("glitch_none", cq.size() - base, 0);
    check_val("glitch_valid", c_if.rx_valid, 0);
    drive_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check_val("post_glitch_count", cq.size() - base, 1);
    if (cq.size() > base) check_val("post_glitch_frame", cq[base], {2'b00, 8'h81});

`ifdef UART_RX_FIFO_EN
    // FIFO fills with 16 frames; the 17th is dropped.
    set_rx_ready_c(1'b0);
    ovr_base = ovr_cnt;
    for (int i = 0; i < 16; i++) drive_frame(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check_val("fifo_no_ovr_16", ovr_cnt - ovr_base, 0);
    drive_frame(8'h10, 1'b1);
    repeat (20) @(negedge clk);
    check_val("fifo_ovr_17", ovr_cnt - ovr_base, 1);
    base = cq.size();
    set_rx_ready_c(1'b1);
    repeat (40) @(negedge clk);
    check_val("fifo_drain_count", cq.size() - base, 16);
    for (int i = 0; i < 16; i++)
      if (base + i < cq.size()) check_val($sformatf("fifo_drain%0d", i), cq[base+i], 10'(i));
    check_val("fifo_empty_valid", c_if.rx_valid, 0);
`else
    // Second frame arrives while the first is still held.
    set_rx_ready_c(1'b0);
    ovr_base = ovr_cnt;
    drive_frame(8'h11, 1'b1);
    drive_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check_val("ovr_valid", c_if.rx_valid, 1);
    check_val("ovr_held_data", c_if.rx_data, 8'h11);
    check_val("ovr_pulses", ovr_cnt - ovr_base, 1);
    set_rx_ready_c(1'b1);
    set_rx_ready_c(1'b0);
    @(negedge clk);
    check_val("ovr_valid_drop", c_if.rx_valid, 0);
    c_if.rx_ready = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
